i2c_target_regfile: RTL and testbench

Synthesizable, parametrised I2C target with an internal register file, replacing the behavioural bus-capture model with clocked RTL. It oversamples SCL/SDA on the system clock and decodes START, repeated START and STOP. It ACKs only addresses matching a programmable address/mask and services auto-incrementing register reads and writes. A parallel host port gives on-chip logic access to the same registers. It sits between the open-drain pad wrappers and the local control logic.

---
 rtl/i2c_target_regfile.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing register file and a parallel host port.
// SCL/SDA are synchronised, glitch-filtered and edge-decoded on the system clock.
module i2c_target_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int FILTER_LEN = 3,
  localparam int PTR_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe_o,
  input  logic [6:0]       dev_addr_i,
  input  logic [6:0]       dev_mask_i,
  input  logic [PTR_W-1:0] host_idx_i,
  input  logic [7:0]       host_wdata_i,
  input  logic             host_we_i,
  output logic [7:0]       host_rdata_o,
  output logic             wr_strobe_o,
  output logic [PTR_W-1:0] wr_idx_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0]       scl_sync, sda_sync;
  logic [3:0]       scl_cnt, sda_cnt;
  logic             scl_f, sda_f, scl_q, sda_q;
  logic             scl_rise, scl_fall, start_c, stop_c;

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shifter;
  logic             rw, first_byte;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       rx_byte;
  logic             addr_match;

  // Idle bus is high, so the conditioning chain resets to 1 to avoid a fake edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end

  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign start_c    = scl_f & sda_q & ~sda_f;
  assign stop_c     = scl_f & ~sda_q & sda_f;
  assign rx_byte    = {shifter[6:0], sda_f};
  assign addr_match = ((shifter[6:0] ^ dev_addr_i) & dev_mask_i) == 7'd0;

  assign host_rdata_o = regs[host_idx_i];
  assign dbg_state_o  = state;

  // Host write is issued first so a same-cycle I2C commit to that index overrides it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shifter     <= '0;
      rw          <= 1'b0;
      first_byte  <= 1'b0;
      ptr         <= '0;
      sda_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_idx_o    <= '0;
      wr_data_o   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe_o <= 1'b0;
      if (host_we_i) regs[host_idx_i] <= host_wdata_i;

      if (start_c) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        busy_o   <= 1'b1;
        sda_oe_o <= 1'b0;
      end else if (stop_c) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        busy_o   <= 1'b0;
        sda_oe_o <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shifter <= rx_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                rw      <= sda_f;
                state   <= addr_match ? ADDR_ACK : WAIT_STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          // First fall starts the ACK; second fall ends it and sets up the data phase.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_o) begin
                sda_oe_o <= 1'b1;
              end else if (rw) begin
                state    <= RD_BYTE;
                sda_oe_o <= ~regs[ptr][7];
                shifter  <= {regs[ptr][6:0], 1'b0};
                bit_cnt  <= '0;
              end else begin
                state      <= WR_BYTE;
                sda_oe_o   <= 1'b0;
                first_byte <= 1'b1;
                bit_cnt    <= '0;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shifter <= rx_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                state   <= WR_ACK;
                if (first_byte) begin
                  ptr        <= rx_byte[PTR_W-1:0];
                  first_byte <= 1'b0;
                end else begin
                  regs[ptr]   <= rx_byte;
                  wr_strobe_o <= 1'b1;
                  wr_idx_o    <= ptr;
                  wr_data_o   <= rx_byte;
                  ptr         <= ptr + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_o) begin
                sda_oe_o <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= WR_BYTE;
              end
            end
          end
          // bit_cnt counts controller samples; the 8th sample's fall hands SDA back.
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                ptr      <= ptr + 1'b1;
                bit_cnt  <= '0;
                state    <= RD_ACK;
              end else begin
                sda_oe_o <= ~shifter[7];
                shifter  <= {shifter[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                state   <= RD_BYTE;
                shifter <= regs[ptr];
                bit_cnt <= '0;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: sda_oe_o <= 1'b0;
          default:   state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bit-banged I2C controller driving i2c_target_regfile, with queue-based scoreboards
// for register commits and for bits the target puts on SDA.
module tb_i2c_target_regfile;
  localparam int NUM_REGS   = 16;
  localparam int FILTER_LEN = 3;
  localparam int PTR_W      = 4;
  localparam int Q          = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             scl_ctrl = 1'b1;
  logic             sda_ctrl = 1'b1;
  logic             sda_oe;
  logic             sda_line;
  logic [6:0]       dev_addr, dev_mask;
  logic [PTR_W-1:0] host_idx;
  logic [7:0]       host_wdata, host_rdata;
  logic             host_we;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic             busy;
  logic [2:0]       dbg_state;

  assign sda_line = sda_ctrl & ~sda_oe;

  i2c_target_regfile #(.NUM_REGS(NUM_REGS), .FILTER_LEN(FILTER_LEN)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_ctrl), .sda_i(sda_line), .sda_oe_o(sda_oe),
    .dev_addr_i(dev_addr), .dev_mask_i(dev_mask), .host_idx_i(host_idx),
    .host_wdata_i(host_wdata), .host_we_i(host_we), .host_rdata_o(host_rdata),
    .wr_strobe_o(wr_strobe), .wr_idx_o(wr_idx), .wr_data_o(wr_data), .busy_o(busy),
    .dbg_state_o(dbg_state)
  );

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [PTR_W+7:0] exp_q[$];
  logic [0:0]       exp_bit_q[$];
  int sample_cnt = 0;
  logic quiet = 1'b0;
  int quiet_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // commit monitor
  always @(negedge clk) begin : wr_mon
    logic [PTR_W+7:0] e;
    if (!rst && wr_strobe) begin
      if (exp_q.size() == 0) begin
        check("wr_strobe_unexpected", {wr_idx, wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_commit", {wr_idx, wr_data}, e);
      end
    end
  end

  // SDA bit monitor
  always @(sample_cnt) begin
    if (sample_cnt != 0) begin
      if (exp_bit_q.size() == 0) check("sda_bit_unexpected", 32'(sda_line), 32'hFFFF_FFFF);
      else check("sda_bit", 32'(sda_line), 32'(exp_bit_q.pop_front()));
    end
  end

  always @(negedge clk) if (quiet && sda_oe) quiet_viol++;

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic collide);
    sda_ctrl = b;
    wait_q();
    scl_ctrl = 1'b1;
    if (collide) begin
      repeat (4) @(negedge clk);
      host_we = 1'b1;
      repeat (2) @(negedge clk);
      host_we = 1'b0;
      repeat (2*Q-6) @(negedge clk);
    end else begin
      repeat (2*Q) @(negedge clk);
    end
    scl_ctrl = 1'b0;
    wait_q();
  endtask

  task automatic read_bit(input logic exp);
    sda_ctrl = 1'b1;
    wait_q();
    scl_ctrl = 1'b1;
    wait_q();
    exp_bit_q.push_back(exp);
    sample_cnt++;
    wait_q();
    scl_ctrl = 1'b0;
    wait_q();
  endtask

  task automatic glitch(input int n);
    scl_ctrl = 1'b1;
    repeat (n) @(negedge clk);
    scl_ctrl = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic ack_exp);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    read_bit(ack_exp);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(exp[i]);
    send_bit(nack, 1'b0);
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; wait_q();
    scl_ctrl = 1'b1; wait_q();
    sda_ctrl = 1'b0; wait_q();
    scl_ctrl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; wait_q();
    scl_ctrl = 1'b1; wait_q();
    sda_ctrl = 1'b1; wait_q();
  endtask

  task automatic host_write(input logic [PTR_W-1:0] idx, input logic [7:0] d);
    @(negedge clk);
    host_idx = idx; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [PTR_W-1:0] idx, input logic [7:0] exp);
    @(negedge clk);
    host_idx = idx;
    #1;
    check(name, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] low7;
    logic [7:0] b;
    dev_addr = 7'h50; dev_mask = 7'h7F;
    host_we = 1'b0; host_idx = '0; host_wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_strobe", 32'(wr_strobe), 0);
    check("rst_wr_idx", 32'(wr_idx), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_reg("rst_reg7", 4'd7, 8'h00);

    // write burst with pointer wrap
    exp_q.push_back({4'd14, 8'h11});
    exp_q.push_back({4'd15, 8'h22});
    exp_q.push_back({4'd0,  8'h33});
    i2c_start();
    check("burst_busy", 32'(busy), 1);
    write_byte(8'hA0, 1'b0);
    write_byte(8'h0E, 1'b0);
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    write_byte(8'h33, 1'b0);
    i2c_stop();
    wait_q();
    check("burst_busy_after_stop", 32'(busy), 0);
    chk_reg("burst_reg14", 4'd14, 8'h11);
    chk_reg("burst_reg15", 4'd15, 8'h22);
    chk_reg("burst_reg0", 4'd0, 8'h33);
    chk_reg("burst_reg1", 4'd1, 8'h00);

    // pointer write, repeated START, read ACK/ACK/NACK
    host_write(4'd3, 8'h5A);
    host_write(4'd4, 8'hC3);
    host_write(4'd5, 8'h81);
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h03, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0);
    read_byte(8'h5A, 1'b0);
    read_byte(8'hC3, 1'b0);
    read_byte(8'h81, 1'b1);
    quiet_viol = 0;
    quiet = 1'b1;
    repeat (2*Q) @(negedge clk);
    check("nack_busy", 32'(busy), 1);
    i2c_stop();
    wait_q();
    quiet = 1'b0;
    check("nack_no_drive", 32'(quiet_viol), 0);
    check("read_busy_after_stop", 32'(busy), 0);

    // address mask
    dev_mask = 7'h7C;
    i2c_start();
    write_byte(8'hA6, 1'b0);
    i2c_stop();
    wait_q();
    quiet_viol = 0;
    i2c_start();
    quiet = 1'b1;
    write_byte(8'hA8, 1'b1);
    check("mask_miss_busy", 32'(busy), 1);
    i2c_stop();
    wait_q();
    quiet = 1'b0;
    check("mask_miss_no_drive", 32'(quiet_viol), 0);
    check("mask_miss_busy_after_stop", 32'(busy), 0);
    dev_mask = 7'h7F;

    // glitch filter: 2-cycle pulse ignored
    exp_q.push_back({4'd7, 8'h3C});
    i2c_start();
    write_byte(8'hA0, 1'b0);
    b = 8'h07;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) glitch(2);
      send_bit(b[i], 1'b0);
    end
    read_bit(1'b0);
    write_byte(8'h3C, 1'b0);
    i2c_stop();
    chk_reg("glitch_short_reg7", 4'd7, 8'h3C);

    // glitch filter: 4-cycle pulse counted as the pointer MSB
    exp_q.push_back({4'd9, 8'h66});
    i2c_start();
    write_byte(8'hA0, 1'b0);
    sda_ctrl = 1'b0;
    wait_q();
    glitch(4);
    low7 = 7'h09;
    for (int i = 6; i >= 0; i--) send_bit(low7[i], 1'b0);
    read_bit(1'b0);
    write_byte(8'h66, 1'b0);
    i2c_stop();
    chk_reg("glitch_long_reg9", 4'd9, 8'h66);

    // host/I2C collision on the same index
    exp_q.push_back({4'd5, 8'h99});
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h05, 1'b0);
    @(negedge clk);
    host_idx = 4'd5; host_wdata = 8'h77;
    b = 8'h99;
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b0);
    send_bit(b[0], 1'b1);
    read_bit(1'b0);
    i2c_stop();
    chk_reg("collision_reg5", 4'd5, 8'h99);
    host_write(4'd6, 8'h44);
    chk_reg("host_write_reg6", 4'd6, 8'h44);

    // reset in the middle of reading 0xA5
    host_write(4'd2, 8'hA5);
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h02, 1'b0);
    i2c_start();
    write_byte(8'hA1, 1'b0);
    read_bit(1'b1);
    read_bit(1'b0);
    read_bit(1'b1);
    check("midread_driving", 32'(sda_oe), 1);
    check("midread_busy", 32'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_sda_oe", 32'(sda_oe), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_state", 32'(dbg_state), 0);
    chk_reg("midrst_reg2", 4'd2, 8'h00);
    chk_reg("midrst_reg5", 4'd5, 8'h00);
    chk_reg("midrst_reg14", 4'd14, 8'h00);
    scl_ctrl = 1'b1;
    sda_ctrl = 1'b1;
    repeat (2*Q) @(negedge clk);

    // decoding resumes at the next START
    exp_q.push_back({4'd0, 8'h42});
    i2c_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h00, 1'b0);
    write_byte(8'h42, 1'b0);
    i2c_stop();
    chk_reg("resume_reg0", 4'd0, 8'h42);

    repeat (20) @(negedge clk);
    check("wr_queue_drained", 32'(exp_q.size()), 0);
    check("bit_queue_drained", 32'(exp_bit_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
